csr_trap_ctrl: RTL

- Parametrised machine-mode CSR file plus trap/interrupt controller for the pipelined RV32I core; sits in XB stage.
- Generalises the single-timer-interrupt CSR/EHU:
  - configurable number of platform-local interrupt lines
  - software/timer/external interrupts with fixed priority
  - mtvec direct or vectored mode
  - mret handling
  - configurable counter width
- Synchronous exceptions decoded upstream arrive as a cause/tval pair.

---
 rtl/csr_trap_ctrl.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/csr_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : csr_trap_ctrl
// Purpose  : Machine-mode CSR file and trap/interrupt controller for the
//            XB stage of the pipelined RV32I core. Handles CSR reads and
//            writes, synchronous exceptions, prioritised level interrupts
//            (software/timer/external plus platform-local lines), direct or
//            vectored mtvec, mret, and the mcycle/minstret counters.
// Ports    : clk, resetb (async active-low)
//            XB_bubble, XB_pc            - XB stage instruction status / PC
//            csr_read/op/addr/wdata      - CSR access request
//            exc_valid/cause/tval        - decoded synchronous exception
//            mret                        - XB instruction is mret
//            irq_soft/timer/ext/local    - level interrupt requests
//            data_out                    - registered CSR read data
//            trap_taken, trap_target     - combinational fetch redirect
//            csr_mepc                    - mret return address
//            illegal_csr                 - current CSR access is illegal
// Revision : 1.0 - initial release
// ============================================================================
module csr_trap_ctrl #(
  parameter int          NUM_LOCAL   = 4,
  parameter int          COUNTER_W   = 64,
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        XB_bubble,
  input  logic [29:0] XB_pc,
  input  logic        csr_read,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        exc_valid,
  input  logic [3:0]  exc_cause,
  input  logic [31:0] exc_tval,
  input  logic        mret,
  input  logic        irq_soft,
  input  logic        irq_timer,
  input  logic        irq_ext,
  input  logic [((NUM_LOCAL > 0) ? NUM_LOCAL : 1)-1:0] irq_local,
  output logic [31:0] data_out,
  output logic        trap_taken,
  output logic [31:0] trap_target,
  output logic [31:0] csr_mepc,
  output logic        illegal_csr
);

  localparam logic [31:0] MISA_VAL   = 32'h4000_0100;
  localparam logic [31:0] LOCAL_MASK = ((32'd1 << NUM_LOCAL) - 32'd1) << 16;
  localparam logic [31:0] MIE_MASK   = LOCAL_MASK | 32'h0000_0888;
  // Counters are held in 64-bit registers; bits at and above COUNTER_W are
  // forced to zero so the wrap point and high-half reads follow COUNTER_W.
  localparam logic [63:0] CNT_MASK   = (COUNTER_W >= 64) ? {64{1'b1}}
                                      : ((64'd1 << COUNTER_W) - 64'd1);

  // Architectural state
  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [31:0] mie_csr;
  logic [31:0] mip_csr;
  logic [29:0] mtvec_base;
  logic        mtvec_vec;
  logic [29:0] mepc_csr;
  logic [31:0] mcause_csr;
  logic [31:0] mtval_csr;
  logic [31:0] mscratch_csr;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  // Combinational helpers
  logic [31:0] rdata;
  logic        implemented;
  logic        eff_write;
  logic        csr_access;
  logic        csr_we;
  logic [31:0] wval;
  logic [31:0] mip_next;
  logic [31:0] pend;
  logic        intr_pend;
  logic [4:0]  int_code;
  logic        sync_trap;
  logic [31:0] trap_cause;
  logic [31:0] mtvec_addr;
  logic        mret_ok;
  logic [63:0] mcycle_next;
  logic [63:0] minstret_next;

  // --------------------------------------------------------------------------
  // CSR read mux and address decode
  // --------------------------------------------------------------------------
  always_comb begin
    rdata       = 32'd0;
    implemented = 1'b1;
    case (csr_addr) inside
      12'hF11, 12'hF12, 12'hF13, 12'hF14: rdata = 32'd0;
      12'h300: rdata = {24'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};
      12'h301: rdata = MISA_VAL;
      12'h304: rdata = mie_csr;
      12'h305: rdata = {mtvec_base, 1'b0, mtvec_vec};
      12'h340: rdata = mscratch_csr;
      12'h341: rdata = {mepc_csr, 2'b00};
      12'h342: rdata = mcause_csr;
      12'h343: rdata = mtval_csr;
      12'h344: rdata = mip_csr;
      12'hB00, 12'hC00: rdata = mcycle[31:0];
      12'hB02, 12'hC02: rdata = minstret[31:0];
      12'hB80, 12'hC80: rdata = mcycle[63:32];
      12'hB82, 12'hC82: rdata = minstret[63:32];
      // hpm counters/events: implemented as hard-wired zero
      [12'h323:12'h33F], [12'hB03:12'hB1F], [12'hB83:12'hB9F],
      [12'hC03:12'hC1F], [12'hC83:12'hC9F]: rdata = 32'd0;
      default: implemented = 1'b0;
    endcase
  end

  // set/clear with a zero operand is a pure read, so it may target
  // read-only CSRs without raising an illegal-instruction trap
  assign eff_write   = (csr_op == 2'b01) | (csr_op[1] & (csr_wdata != 32'd0));
  assign csr_access  = ~XB_bubble & (csr_read | (csr_op != 2'b00));
  assign illegal_csr = csr_access &
                       (~implemented | ((csr_addr[11:10] == 2'b11) & eff_write));

  always_comb begin
    case (csr_op)
      2'b01:   wval = csr_wdata;
      2'b10:   wval = rdata | csr_wdata;
      2'b11:   wval = rdata & ~csr_wdata;
      default: wval = rdata;
    endcase
  end

  // A trapping instruction does not retire, so its CSR write is dropped
  assign csr_we = ~XB_bubble & eff_write & ~illegal_csr & ~trap_taken;

  // --------------------------------------------------------------------------
  // Interrupt sampling and priority
  // --------------------------------------------------------------------------
  always_comb begin
    mip_next     = 32'd0;
    mip_next[3]  = irq_soft;
    mip_next[7]  = irq_timer;
    mip_next[11] = irq_ext;
    for (int i = 0; i < NUM_LOCAL; i++) begin
      mip_next[16+i] = irq_local[i];
    end
  end

  assign pend      = mip_csr & mie_csr;
  assign intr_pend = mstatus_mie & (pend != 32'd0);

  // Lowest priority first so later assignments override:
  // local (ascending, highest index wins) < timer < soft < ext
  always_comb begin
    int_code = 5'd0;
    for (int i = 16; i < 32; i++) begin
      if (pend[i]) int_code = 5'(i);
    end
    if (pend[7])  int_code = 5'd7;
    if (pend[3])  int_code = 5'd3;
    if (pend[11]) int_code = 5'd11;
  end

  // --------------------------------------------------------------------------
  // Trap arbitration and redirect
  // --------------------------------------------------------------------------
  assign sync_trap  = ~XB_bubble & (exc_valid | illegal_csr);
  assign trap_taken = resetb & (intr_pend | sync_trap);

  always_comb begin
    if (intr_pend)      trap_cause = {1'b1, 26'd0, int_code};
    else if (exc_valid) trap_cause = {28'd0, exc_cause};
    else                trap_cause = 32'd2;
  end

  assign mtvec_addr  = {mtvec_base, 2'b00};
  assign trap_target = (intr_pend & mtvec_vec)
                       ? (mtvec_addr + {25'd0, int_code, 2'b00})
                       : mtvec_addr;
  assign csr_mepc    = {mepc_csr, 2'b00};
  assign mret_ok     = ~XB_bubble & mret & ~trap_taken;

  // --------------------------------------------------------------------------
  // Counters: a CSR write to either half replaces that cycle's increment
  // --------------------------------------------------------------------------
  always_comb begin
    mcycle_next   = (mcycle + 64'd1) & CNT_MASK;
    minstret_next = minstret;
    if (~XB_bubble & ~trap_taken) minstret_next = (minstret + 64'd1) & CNT_MASK;
    if (csr_we) begin
      case (csr_addr)
        12'hB00: mcycle_next   = {mcycle[63:32], wval} & CNT_MASK;
        12'hB80: mcycle_next   = {wval, mcycle[31:0]} & CNT_MASK;
        12'hB02: minstret_next = {minstret[63:32], wval} & CNT_MASK;
        12'hB82: minstret_next = {wval, minstret[31:0]} & CNT_MASK;
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State update
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      data_out     <= 32'd0;
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_csr      <= 32'd0;
      mip_csr      <= 32'd0;
      mtvec_base   <= RESET_MTVEC[31:2];
      mtvec_vec    <= (RESET_MTVEC[1:0] == 2'b01);
      mepc_csr     <= 30'd0;
      mcause_csr   <= 32'd0;
      mtval_csr    <= 32'd0;
      mscratch_csr <= 32'd0;
      mcycle       <= 64'd0;
      minstret     <= 64'd0;
    end else begin
      mip_csr  <= mip_next;
      mcycle   <= mcycle_next;
      minstret <= minstret_next;
      if (csr_read & implemented) data_out <= rdata;

      if (trap_taken) begin
        mepc_csr     <= XB_pc;
        mcause_csr   <= trap_cause;
        mtval_csr    <= (~intr_pend & exc_valid) ? exc_tval : 32'd0;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else begin
        if (mret_ok) begin
          mstatus_mie  <= mstatus_mpie;
          mstatus_mpie <= 1'b1;
        end
        if (csr_we) begin
          case (csr_addr)
            12'h300: begin
              mstatus_mie  <= wval[3];
              mstatus_mpie <= wval[7];
            end
            12'h304: mie_csr <= wval & MIE_MASK;
            12'h305: begin
              mtvec_base <= wval[31:2];
              // reserved modes 10/11 collapse to direct
              mtvec_vec  <= (wval[1:0] == 2'b01);
            end
            12'h340: mscratch_csr <= wval;
            12'h341: mepc_csr     <= wval[31:2];
            12'h342: mcause_csr   <= wval;
            12'h343: mtval_csr    <= wval;
            default: ;
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire
